// File: rtl/rns_pkg.sv
// Shared definitions for the RNS ALU: opcode encoding, per-lane moduli and the
// default residue width.
package rns_pkg;

  localparam int RES_WID_DEF = 8;
  localparam int MAX_DOMAINS = 4;

  localparam int unsigned MODULI [MAX_DOMAINS] = '{251, 241, 239, 233};

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_PASS = 2'b11
  } rns_op_e;

endpackage

// File: rtl/rns_lane.sv
// One residue lane: operand range check, modular add/sub/pass, and (when
// RNS_MUL_EN is defined) an MSB-first shift-and-add modular multiplier.
module rns_lane
  import rns_pkg::*;
#(
  parameter int          RES_WID = RES_WID_DEF,
  parameter int unsigned MODULUS = 251
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_accept,
  input  logic [1:0]         i_op,
  input  logic [RES_WID-1:0] i_a,
  input  logic [RES_WID-1:0] i_b,
`ifdef RNS_MUL_EN
  input  logic               i_step,
  input  logic               i_last,
`endif
  output logic [RES_WID-1:0] o_res,
  output logic               o_err
);

  localparam logic [RES_WID:0] M_EXT = (RES_WID+1)'(MODULUS);

  // Operands are below the modulus, so one conditional subtract suffices.
  function automatic logic [RES_WID-1:0] add_mod(input logic [RES_WID-1:0] x,
                                                 input logic [RES_WID-1:0] y);
    logic [RES_WID:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= M_EXT) s = s - M_EXT;
    return RES_WID'(s);
  endfunction

  function automatic logic [RES_WID-1:0] sub_mod(input logic [RES_WID-1:0] x,
                                                 input logic [RES_WID-1:0] y);
    logic [RES_WID:0] s;
    s = {1'b0, x} - {1'b0, y};
    if (x < y) s = s + M_EXT;
    return RES_WID'(s);
  endfunction

  logic               w_range_err;
  logic               w_err;
  logic [RES_WID-1:0] w_res;
  logic [RES_WID-1:0] r_res;
  logic               r_err;

  assign w_range_err = ({1'b0, i_a} >= M_EXT) || ({1'b0, i_b} >= M_EXT);

  always_comb begin
    w_res = '0;
    w_err = w_range_err;
    case (i_op)
      OP_ADD:  w_res = add_mod(i_a, i_b);
      OP_SUB:  w_res = sub_mod(i_a, i_b);
      OP_PASS: w_res = i_a;
      default: begin
`ifndef RNS_MUL_EN
        w_err = 1'b1;
`endif
      end
    endcase
    if (w_err) w_res = '0;
  end

`ifdef RNS_MUL_EN
  logic [RES_WID-1:0] r_a;
  logic [RES_WID-1:0] r_b;
  logic [RES_WID-1:0] r_acc;
  logic               r_bad;
  logic [RES_WID-1:0] w_acc_dbl;
  logic [RES_WID-1:0] w_acc_next;

  assign w_acc_dbl  = add_mod(r_acc, r_acc);
  assign w_acc_next = r_b[RES_WID-1] ? add_mod(w_acc_dbl, r_a) : w_acc_dbl;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_res <= '0;
      r_err <= 1'b0;
`ifdef RNS_MUL_EN
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_bad <= 1'b0;
`endif
    end else begin
      if (i_accept) begin
`ifdef RNS_MUL_EN
        if (i_op == OP_MUL) begin
          r_a   <= i_a;
          r_b   <= i_b;
          r_acc <= '0;
          r_bad <= w_range_err;
        end else begin
          r_res <= w_res;
          r_err <= w_err;
        end
`else
        r_res <= w_res;
        r_err <= w_err;
`endif
      end
`ifdef RNS_MUL_EN
      if (i_step) begin
        r_acc <= w_acc_next;
        r_b   <= {r_b[RES_WID-2:0], 1'b0};
        if (i_last) begin
          r_res <= r_bad ? '0 : w_acc_next;
          r_err <= r_bad;
        end
      end
`endif
    end
  end

  assign o_res = r_res;
  assign o_err = r_err;

endmodule

// File: rtl/rns_alu_pipe.sv
// Multi-lane residue-number-system ALU with valid/ready handshake and a shared
// control FSM. Define RNS_MUL_EN to build the iterative modular multiplier.
module rns_alu_pipe
  import rns_pkg::*;
#(
  parameter int NUM_DOMAINS = 1,
  parameter int RES_WID     = RES_WID_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_op,
  input  logic [2:0]                     in_tag,
  input  logic [NUM_DOMAINS*RES_WID-1:0] op_a,
  input  logic [NUM_DOMAINS*RES_WID-1:0] op_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_DOMAINS*RES_WID-1:0] out_data,
  output logic [2:0]                     out_tag,
  output logic [NUM_DOMAINS-1:0]         out_err
);

  if (NUM_DOMAINS < 1 || NUM_DOMAINS > MAX_DOMAINS) begin : g_bad_cfg
    $error("rns_alu_pipe: NUM_DOMAINS must be 1..4");
  end

`ifdef RNS_MUL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_MUL_BUSY, ST_HOLD} state_e;
  localparam int CNT_W = $clog2(RES_WID + 1);
  logic [CNT_W-1:0] r_count;
  logic             w_mul_step;
  logic             w_mul_last;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_HOLD} state_e;
`endif

  state_e     r_state;
  state_e     w_state_next;
  state_e     w_target;
  logic       w_in_ready;
  logic       w_accept;
  logic [2:0] r_tag;

  always_comb begin
    w_in_ready   = !flush && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready));
    w_accept     = in_valid && w_in_ready;
    w_target     = ST_HOLD;
`ifdef RNS_MUL_EN
    if (in_op == OP_MUL) w_target = ST_MUL_BUSY;
`endif
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (w_accept) w_state_next = w_target;
        else if ((r_state == ST_HOLD) && out_ready) w_state_next = ST_IDLE;
      end
`ifdef RNS_MUL_EN
      ST_MUL_BUSY: if (w_mul_last) w_state_next = ST_HOLD;
`endif
      default: w_state_next = ST_IDLE;
    endcase
    if (flush) w_state_next = ST_IDLE;
  end

`ifdef RNS_MUL_EN
  // Lanes are frozen while flushing so a killed multiply never reaches the output.
  assign w_mul_step = (r_state == ST_MUL_BUSY) && !flush;
  assign w_mul_last = w_mul_step && (r_count == CNT_W'(RES_WID - 1));
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_tag   <= '0;
`ifdef RNS_MUL_EN
      r_count <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_tag <= in_tag;
`ifdef RNS_MUL_EN
      if (w_accept) r_count <= '0;
      else if (w_mul_step) r_count <= r_count + CNT_W'(1);
`endif
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == ST_HOLD);
  assign out_tag   = r_tag;

  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_lane
    rns_lane #(
      .RES_WID (RES_WID),
      .MODULUS (MODULI[gi])
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_accept (w_accept),
      .i_op     (in_op),
      .i_a      (op_a[gi*RES_WID +: RES_WID]),
      .i_b      (op_b[gi*RES_WID +: RES_WID]),
`ifdef RNS_MUL_EN
      .i_step   (w_mul_step),
      .i_last   (w_mul_last),
`endif
      .o_res    (out_data[gi*RES_WID +: RES_WID]),
      .o_err    (out_err[gi])
    );
  end

endmodule
